// File: rtl/sxw_ram_delay_bank.sv
`default_nettype none
// ============================================================================
// Module      : sxw_ram_delay_bank
// Description : Simple dual-port RAM (one write port, one registered read
//               port) followed by an enable-gated delay pipeline on the read
//               data.
//
//   Ports
//     clk         rising-edge clock for all state
//     rst         asynchronous reset, active low (clears q and the pipeline,
//                 never the memory array)
//     we          write enable: mem[write_addr] <= data
//     enable      advance enable for the delay pipeline
//     data        write data, WIDTH bits
//     write_addr  write address, ADDR_WIDTH bits
//     read_addr   read address, ADDR_WIDTH bits
//     q           registered read data (1-cycle latency, read-first)
//     q_delay     q delayed by DELAY enabled cycles
//
//   Parameters
//     WIDTH       data word width
//     ADDR_WIDTH  address width, depth = 2**ADDR_WIDTH
//     DELAY       number of pipeline stages after q, 1..16
//
// Revision    : 1.0  initial release
// ============================================================================
module sxw_ram_delay_bank #(
    parameter int WIDTH      = 72,
    parameter int ADDR_WIDTH = 8,
    parameter int DELAY      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      q_delay
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
            $error("sxw_ram_delay_bank: DELAY must be in 1..16");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem   [c_DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_stage [DELAY];

    // Memory array carries no reset so it can map onto block RAM. The write
    // is qualified by the reset level so that writes are dropped while the
    // block is held in reset.
    always_ff @(posedge clk) begin
        if (rst && we) begin
            r_mem[write_addr] <= data;
        end
    end

    // Registered read. Because the array update above is non-blocking, a
    // read of the address being written returns the old contents
    // (read-first behaviour).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_mem[read_addr];
        end
    end

    // Delay chain: stage 0 loads q, each later stage loads its predecessor;
    // the whole chain freezes while enable is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (enable) begin
            r_stage[0] <= r_q;
            for (int i = 1; i < DELAY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q       = r_q;
    assign q_delay = r_stage[DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_sxw_ram_delay_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sxw_ram_delay_bank
// Description : Self-checking bench for sxw_ram_delay_bank. Two instances
//               share all inputs (DELAY=1 and DELAY=3). A reference model
//               built from an array memory and a history queue of enabled q
//               samples predicts outputs; predictions go into a scoreboard
//               queue that a monitor drains after every clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sxw_ram_delay_bank;

    localparam int c_W     = 72;
    localparam int c_AW    = 8;
    localparam int c_DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            we = 1'b0;
    logic            enable = 1'b0;
    logic [c_W-1:0]  data = '0;
    logic [c_AW-1:0] write_addr = '0;
    logic [c_AW-1:0] read_addr = '0;
    logic [c_W-1:0]  q1, qd1, q3, qd3;

    always #5 clk = ~clk;

    sxw_ram_delay_bank #(.WIDTH(c_W), .ADDR_WIDTH(c_AW), .DELAY(1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .enable(enable), .data(data),
        .write_addr(write_addr), .read_addr(read_addr), .q(q1), .q_delay(qd1)
    );

    sxw_ram_delay_bank #(.WIDTH(c_W), .ADDR_WIDTH(c_AW), .DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst), .we(we), .enable(enable), .data(data),
        .write_addr(write_addr), .read_addr(read_addr), .q(q3), .q_delay(qd3)
    );

    typedef struct packed {
        logic           chk;
        logic [c_W-1:0] q;
        logic [c_W-1:0] qd1;
        logic [c_W-1:0] qd3;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [c_W-1:0] m_mem [c_DEPTH];
    logic [c_W-1:0] m_q = '0;
    logic [c_W-1:0] h1[$];
    logic [c_W-1:0] h3[$];

    initial begin
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = '0;
    end

    task automatic check(input string name, input logic [c_W-1:0] act,
                         input logic [c_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // q_delay of a DELAY-d chain is the q value captured d enabled edges ago.
    function automatic logic [c_W-1:0] tail(input logic [c_W-1:0] h[$], input int d);
        if (h.size() >= d) return h[h.size()-d];
        return '0;
    endfunction

    function automatic logic [c_W-1:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[c_W-1:0];
    endfunction

    // One clock cycle of stimulus: drive at negedge, predict the state after
    // the following posedge and hand the prediction to the monitor.
    task automatic step(input logic r, input logic w, input logic en,
                        input logic [c_AW-1:0] wa, input logic [c_AW-1:0] ra,
                        input logic [c_W-1:0] d, input logic chk);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; enable = en; write_addr = wa; read_addr = ra; data = d;
        if (!r) begin
            m_q = '0;
            h1.delete();
            h3.delete();
        end else begin
            if (en) begin
                h1.push_back(m_q);
                h3.push_back(m_q);
                while (h1.size() > 1) void'(h1.pop_front());
                while (h3.size() > 3) void'(h3.pop_front());
            end
            m_q = m_mem[ra];
            if (w) m_mem[wa] = d;
        end
        e.chk = chk;
        e.q   = m_q;
        e.qd1 = tail(h1, 1);
        e.qd3 = tail(h3, 3);
        sb.push_back(e);
    endtask

    // Directed check of one output shortly after the next rising edge.
    // sel: 0 = q, 1 = q_delay (DELAY=1), 2 = q_delay (DELAY=3)
    task automatic chk_after(input string name, input logic [c_W-1:0] exp, input int sel);
        @(posedge clk);
        #2;
        if (sel == 0)      check(name, q1, exp);
        else if (sel == 1) check(name, qd1, exp);
        else               check(name, qd3, exp);
    endtask

    // Pulse reset low between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_q", q1, '0);
        check("async_rst_qd1", qd1, '0);
        check("async_rst_qd3", qd3, '0);
        m_q = '0;
        h1.delete();
        h3.delete();
        #1;
        rst = 1'b1;
    endtask

    // Monitor: every edge, pop the prediction made for it and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("sb_q1", q1, e.q);
                check("sb_q3", q3, e.q);
                check("sb_qd1", qd1, e.qd1);
                check("sb_qd3", qd3, e.qd3);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_W-1:0] v5, v7, d;
        logic [c_AW-1:0] wa, ra;
        int wait_cnt;
        v5 = 72'hFF_0012_3456_789A_BCDE;
        v7 = rnd72();

        // Held in reset: outputs stay zero
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        check("reset_q", q1, '0);
        check("reset_qd", qd1, '0);

        // Fill every address with its own index; read data still undefined
        for (int i = 0; i < c_DEPTH; i++)
            step(1'b1, 1'b1, 1'b1, c_AW'(i), c_AW'(i), c_W'(i), 1'b0);
        pulse_reset();

        // Top and bottom address, no aliasing
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd255, '0, 1'b1);
        chk_after("read_255", c_W'(255), 0);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        chk_after("read_0", c_W'(0), 0);

        // Write 5, read back through q then q_delay
        step(1'b1, 1'b1, 1'b1, 8'd5, 8'd0, v5, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd5, '0, 1'b1);
        chk_after("addr5_q", v5, 0);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd5, '0, 1'b1);
        chk_after("addr5_qd", v5, 1);

        // Read-during-write is read-first
        step(1'b1, 1'b1, 1'b1, 8'd3, 8'd0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd3, 8'd3, c_W'(72'hA5), 1'b1);
        chk_after("rdw_old", '0, 0);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd3, '0, 1'b1);
        chk_after("rdw_new", c_W'(72'hA5), 0);

        // Enable gating
        step(1'b1, 1'b1, 1'b1, 8'd10, 8'd0, c_W'(1), 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd11, 8'd0, c_W'(2), 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd10, '0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd10, '0, 1'b1);
        chk_after("en_prior", c_W'(1), 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'd0, 8'd11, '0, 1'b1);
            chk_after("en_hold", c_W'(1), 1);
        end
        check("en_hold_q", q1, c_W'(2));
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd11, '0, 1'b1);
        chk_after("en_resume", c_W'(2), 1);

        // DELAY=3 sequence
        step(1'b1, 1'b1, 1'b1, 8'd20, 8'd0, c_W'(1), 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd21, 8'd0, c_W'(2), 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd22, 8'd0, c_W'(3), 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd20, '0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd21, '0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd22, '0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        chk_after("d3_1", c_W'(1), 2);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        chk_after("d3_2", c_W'(2), 2);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        chk_after("d3_3", c_W'(3), 2);

        // Mid-operation reset keeps memory
        step(1'b1, 1'b1, 1'b1, 8'd7, 8'd20, v7, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd21, '0, 1'b1);
        pulse_reset();
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd7, '0, 1'b1);
        chk_after("post_rst_read7", v7, 0);

        // Writes ignored while reset is held
        step(1'b0, 1'b1, 1'b1, 8'd7, 8'd7, ~v7, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'd7, 8'd7, ~v7, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd7, '0, 1'b1);
        chk_after("rst_write_ignored", v7, 0);

        // Randomised traffic, addresses often confined to force collisions
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                wa = c_AW'($urandom_range(0, 7));
                ra = c_AW'($urandom_range(0, 7));
            end else begin
                wa = c_AW'($urandom);
                ra = c_AW'($urandom);
            end
            d = rnd72();
            step(($urandom_range(0, 39) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                 wa, ra, d, 1'b1);
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        // Drain the scoreboard with a bounded wait
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, '0, 1'b1);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sxw_ram_delay_bank.md
SXW_RAM_DELAY_BANK -- requirements
Module: sxw_ram_delay_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port is named clk and reset port is named rst, per codebase convention.
REQ-002 Parameter WIDTH, default 72: data word width in bits.
REQ-003 Parameter ADDR_WIDTH, default 8: address width; memory depth SHALL be 2**ADDR_WIDTH words.
REQ-004 Parameter DELAY, default 1: number of enable-gated register stages after the RAM read port; legal range 1..16.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 we  input  1  RAM write enable.
REQ-008 enable  input  1  advance enable for the delay pipeline.
REQ-009 data  input  WIDTH  RAM write data.
REQ-010 write_addr  input  ADDR_WIDTH  RAM write address.
REQ-011 read_addr  input  ADDR_WIDTH  RAM read address.
REQ-012 q  output  WIDTH  registered RAM read data.
REQ-013 q_delay  output  WIDTH  q delayed by DELAY enabled cycles.

Function
REQ-014 On a rising clk edge with we=1, mem[write_addr] SHALL take data.
REQ-015 On every rising clk edge, q SHALL take mem[read_addr], independent of we and enable; read latency is exactly 1 cycle.
REQ-016 Read-during-write to the same address SHALL be read-first: q takes the pre-write contents, and the new value is visible one cycle later.
REQ-017 Writes and reads to different addresses in the same cycle SHALL not interact.
REQ-018 Memory contents SHALL not be cleared by rst; contents are undefined until written. Simulation initialises all words to 0.
REQ-019 The delay pipeline SHALL be a chain of DELAY registers, each WIDTH bits wide. Stage 0 loads q, stage k loads stage k-1, and q_delay is the last stage.
REQ-020 Pipeline stages SHALL update only on rising clk edges where enable=1 and SHALL hold their value when enable=0.
REQ-021 With DELAY=1 and enable held high, q_delay SHALL equal the q value of the previous cycle, giving 2 cycles from read_addr to q_delay.
REQ-022 Addresses SHALL wrap naturally: all ADDR_WIDTH-bit values are valid and no out-of-range condition exists.
REQ-023 Simultaneous we=1 and enable=1 SHALL both take effect in the same cycle.

Reset
REQ-024 While rst=0, q and every pipeline stage, and therefore q_delay, SHALL be 0 immediately and asynchronously, without waiting for a clock edge.
REQ-025 While rst=0, writes with we=1 SHALL be ignored.
REQ-026 After rst deasserts, the first rising edge SHALL resume normal read and write operation.
REQ-027 Reset asserted mid-operation SHALL clear q and the pipeline on the same instant, and SHALL leave memory intact.

Verification
REQ-028 Write 72'hFF00_1234_5678_9ABC_DE to address 5, then read address 5 -> q equals that value 1 cycle after the read address is presented; with enable=1, q_delay equals it 1 cycle later (DELAY=1).
REQ-029 Address 3 holds 0. In one cycle, write 72'hA5 to address 3 and read address 3 -> q=0 that cycle, and q=72'hA5 on the following read.
REQ-030 Load q=72'h1, then hold enable=0 for 4 cycles while q changes to 72'h2 -> q_delay stays at its prior value. Raise enable -> q_delay becomes 72'h2 after 1 edge.
REQ-031 Fill addresses 0..255 with their own index, then read 255 then 0 -> q returns 255 then 0 with no aliasing.
REQ-032 Write address 7, then pulse rst low between clock edges -> q and q_delay go to 0 immediately. After release, reading address 7 returns the written data.
REQ-033 DELAY=3, enable=1, sequential reads of addresses holding 1,2,3 -> q_delay presents 1,2,3 exactly 3 cycles after q does.
